// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {F_BOOT, F_REQ, F_DRAIN, F_TRAP} fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam logic [63:0] ALIGN_MASK = ~64'h3;
endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: redirect (masked target) beats advance (+4) beats hold.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             redirect,
  input  logic             advance,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] next_pc
);

  assign pc4 = pc + WIDTH'(INSTR_BYTES);

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = target & WIDTH'(ALIGN_MASK);
    end else if (advance) begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: one-outstanding imem req/ack, redirect with flush and drain.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky misalign_err and parks in F_TRAP.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic             misalign_err
`endif
);

  fetch_state_t     state, state_nxt;
  logic [WIDTH-1:0] pc, pc4, next_pc, drain_addr;
  logic             redirect, advance, consume, misalign, to_trap;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    case (state)
      F_REQ: begin
        imem_req  = ~if_valid | ~stall;
        imem_addr = pc;
      end
      F_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      default: ;
    endcase
  end

  assign redirect = br_taken & ((state == F_REQ) | (state == F_DRAIN));
  assign advance  = (state == F_REQ) & imem_req & imem_ack;
  assign consume  = if_valid & ~stall;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = redirect & (br_target[1:0] != 2'b00);
  assign to_trap  = misalign | misalign_err;
`else
  assign misalign = 1'b0;
  assign to_trap  = 1'b0;
`endif

  fetch_pc_next #(.WIDTH(WIDTH)) u_pc_next (
    .redirect (redirect),
    .advance  (advance),
    .pc       (pc),
    .target   (br_target),
    .pc4      (pc4),
    .next_pc  (next_pc)
  );

  // An unacked request must complete before fetching the new target (or trapping).
  always_comb begin
    state_nxt = state;
    case (state)
      F_BOOT: state_nxt = F_REQ;
      F_REQ, F_DRAIN: begin
        if (imem_req && !imem_ack && (redirect || state == F_DRAIN)) begin
          state_nxt = F_DRAIN;
        end else if (to_trap) begin
          state_nxt = F_TRAP;
        end else begin
          state_nxt = F_REQ;
        end
      end
      default: state_nxt = F_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= F_BOOT;
      pc         <= RESET_PC;
      drain_addr <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc4     <= '0;
    end else begin
      state <= state_nxt;
      pc    <= next_pc;
      if (state == F_REQ) begin
        drain_addr <= pc;
      end
      if (redirect) begin
        if_valid <= 1'b0;
      end else if (advance) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_pc4   <= pc4;
      end else if (consume) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (misalign) begin
      misalign_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized stall/redirect/ack-delay traffic.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  fetch_pc_ctrl #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: fetch stream as the specification describes it.
  bit          boot;
  bit          exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_if_pc;
  bit          stale;
  bit          prev_pend;
  logic [31:0] prev_addr;
  bit          trap_seen;
  int          wait_cnt;
  int          max_wait;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_init();
    boot      = 1'b1;
    exp_valid = 1'b0;
    exp_pc    = 32'h0;
    exp_if_pc = 32'h0;
    stale     = 1'b0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    trap_seen = 1'b0;
    wait_cnt  = 0;
  endtask

  task automatic check_cycle();
    if (boot) begin
      chk("boot_req", {31'b0, imem_req}, 32'd0);
    end else if (!trap_seen) begin
      chk("req_rule", {31'b0, imem_req}, {31'b0, (!exp_valid || !stall)});
    end else if (!stale) begin
      chk("trap_req", {31'b0, imem_req}, 32'd0);
    end
    if (prev_pend) begin
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    if (!boot && !trap_seen && !stale && imem_req) begin
      chk("fetch_addr", imem_addr, exp_pc);
    end
    chk("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("if_pc", if_pc, exp_if_pc);
      chk("if_instr", if_instr, mem_word(exp_if_pc));
      chk("if_pc4", if_pc4, exp_if_pc + 32'd4);
    end
  endtask

  task automatic model_update();
    bit fire;
    fire = imem_req && imem_ack;
    if (boot) begin
      boot = 1'b0;
    end else if (br_taken && !trap_seen) begin
      exp_valid = 1'b0;
      exp_pc    = br_target & ~32'h3;
      stale     = imem_req && !imem_ack;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (br_target[1:0] != 2'b00) trap_seen = 1'b1;
`endif
    end else if (fire && stale) begin
      stale = 1'b0;
    end else if (fire && !trap_seen) begin
      exp_valid = 1'b1;
      exp_if_pc = exp_pc;
      exp_pc    = exp_pc + 32'd4;
    end else if (exp_valid && !stall) begin
      exp_valid = 1'b0;
    end
    prev_pend = imem_req && !imem_ack;
    prev_addr = imem_addr;
  endtask

  // One clock cycle: drive inputs, let the memory answer, then check and advance the model.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    stall     = s;
    br_taken  = b;
    br_target = t;
    #1;
    if (imem_req) begin
      if (wait_cnt == 0) begin
        imem_ack = 1'b1;
        wait_cnt = int'($urandom_range(0, max_wait));
      end else begin
        imem_ack = 1'b0;
        wait_cnt--;
      end
    end else begin
      imem_ack = 1'b0;
    end
    imem_rdata = mem_word(imem_addr);
    #1;
    check_cycle();
    model_update();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_merr", {31'b0, misalign_err}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_init();
  endtask

  initial begin
    logic [31:0] tgt;
    max_wait = 0;
    model_init();
    do_reset();

    // Zero-wait streaming from reset.
    step(0, 0, 0); chk("boot_idle", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0); chk("addr0", imem_addr, 32'h0);
    step(0, 0, 0); chk("addr4", imem_addr, 32'h4); chk("pc4_of_0", if_pc4, 32'h4);
    step(0, 0, 0); chk("addr8", imem_addr, 32'h8); chk("ifpc_4", if_pc, 32'h4);

    // Three stall cycles with a valid instruction held.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_noreq", {31'b0, imem_req}, 32'd0);
    end
    step(0, 0, 0); chk("resume_addr", imem_addr, 32'hC);

    // Redirect while a request waits on a delayed ack.
    wait_cnt = 2;
    step(0, 0, 0); chk("pre_drain_addr", imem_addr, 32'h10);
    step(0, 1, 32'h40);
    step(0, 0, 0); chk("drain_flush", {31'b0, if_valid}, 32'd0);
    step(0, 0, 0); chk("tgt_addr", imem_addr, 32'h40);
    step(0, 0, 0); chk("tgt_ifpc", if_pc, 32'h40);

    // Redirect together with stall.
    step(1, 1, 32'h100);
    step(0, 0, 0); chk("br_stall_flush", {31'b0, if_valid}, 32'd0);
    chk("br_stall_addr", imem_addr, 32'h100);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0); chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0); chk("wrap_pc4", if_pc4, 32'h0); chk("wrap_next", imem_addr, 32'h0);

    // Randomized traffic.
    max_wait = 2;
    for (int i = 0; i < 1500; i++) begin
      tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = tgt & ~32'h3;
`endif
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), tgt);
    end

    // Reset asserted mid-request.
    wait_cnt = 5;
    step(0, 0, 0); chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, if_valid}, 32'd0);
    do_reset();
    max_wait = 1;
    for (int i = 0; i < 200; i++) begin
      tgt = $urandom & ~32'h3;
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 15) == 0), tgt);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    max_wait = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(0, 1, 32'h42);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      chk("trap_merr", {31'b0, misalign_err}, 32'd1);
      chk("trap_noreq", {31'b0, imem_req}, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
